vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA controller.
- Generates H/V timing for any mode set by parameters, with programmable sync polarity and a run/stop FSM that stops only on frame boundaries.
- Compensates a configurable pixel-source read latency so that RGB, sync and data-enable leave the block aligned.
- Sits between the frame/sprite pixel source (driven by px_h/px_v) and the VGA pins.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_delay_line.sv | 31 +++
 rtl/vga_timing_gen.sv | 158 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and mode tables for the VGA timing generator.
// Modes are full H/V timing sets; axis_total sums one axis.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } mode_t;

  localparam mode_t MODE_640X480_60 = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam mode_t MODE_800X600_60 = '{800, 40, 128, 88, 600, 1, 4, 23};

  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// DEPTH-stage shift register with async reset to a per-bit value.
// DEPTH=0 degenerates to a wire.
module vga_delay_line #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             px_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge px_clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with frame-boundary run/stop and pixel-source latency compensation.
// Optional colour-bar generator when VGA_TEST_PATTERN_EN is defined (adds test_sel input).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PX_LAT   = 2,
  parameter int CW       = 11,
  parameter int COLOR_W  = 4
) (
  input  logic                   px_clk,
  input  logic                   rst,
  input  logic                   en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                   test_sel,
`endif
  input  logic [3*COLOR_W-1:0]   px_data,
  output logic [CW-1:0]          px_h,
  output logic [CW-1:0]          px_v,
  output logic                   px_req,
  output logic [COLOR_W-1:0]     RED,
  output logic [COLOR_W-1:0]     GRN,
  output logic [COLOR_W-1:0]     BLU,
  output logic                   HSYNC,
  output logic                   VSYNC,
  output logic                   de,
  output logic                   frame_start,
  output logic                   line_start,
  output logic                   running
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL - 1 >= (1 << CW) || V_TOTAL - 1 >= (1 << CW)) begin : g_cw_check
    $error("vga_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits");
  end
  if (PX_LAT < 0 || PX_LAT > 8) begin : g_lat_check
    $error("vga_timing_gen: PX_LAT must be within 0..8");
  end

  state_t        state;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          h_last, v_last;

  assign h_last  = (int'(hcnt) == H_TOTAL - 1);
  assign v_last  = (int'(vcnt) == V_TOTAL - 1);
  assign running = (state != IDLE);

  // Counters free-run in RUN and STOP_PEND; en wins over the frame-end stop.
  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hcnt  <= '0;
      vcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          hcnt <= '0;
          vcnt <= '0;
          if (en) state <= RUN;
        end
        RUN, STOP_PEND: begin
          hcnt <= h_last ? '0 : hcnt + 1'b1;
          if (h_last) vcnt <= v_last ? '0 : vcnt + 1'b1;
          if (en)                   state <= RUN;
          else if (state == RUN)    state <= STOP_PEND;
          else if (h_last && v_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic h_act, v_act, de_raw, fs_raw, ls_raw, hs_raw, vs_raw;

  assign h_act  = (int'(hcnt) < H_ACTIVE);
  assign v_act  = (int'(vcnt) < V_ACTIVE);
  assign de_raw = running && h_act && v_act;
  assign fs_raw = running && hcnt == '0 && vcnt == '0;
  assign ls_raw = running && hcnt == '0 && v_act;
  assign hs_raw = (running && int'(hcnt) >= H_ACTIVE + H_FP
                           && int'(hcnt) <  H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
  assign vs_raw = (running && int'(vcnt) >= V_ACTIVE + V_FP
                           && int'(vcnt) <  V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;

  assign px_req = de_raw;
  assign px_h   = de_raw ? hcnt : '0;
  assign px_v   = de_raw ? vcnt : '0;

`ifdef VGA_TEST_PATTERN_EN
  localparam int DW = 5 + CW;
  localparam logic [DW-1:0] DL_RST = {~HS_POL, ~VS_POL, 3'b000, {CW{1'b0}}};
  logic [DW-1:0] raw_vec, dly_vec;
  logic [CW-1:0] d_h;
  logic [2:0]    bar;
  assign raw_vec = {hs_raw, vs_raw, de_raw, fs_raw, ls_raw, hcnt};
  assign d_h     = dly_vec[CW-1:0];
`else
  localparam int DW = 5;
  localparam logic [DW-1:0] DL_RST = {~HS_POL, ~VS_POL, 3'b000};
  logic [DW-1:0] raw_vec, dly_vec;
  assign raw_vec = {hs_raw, vs_raw, de_raw, fs_raw, ls_raw};
`endif

  // Delay matches the pixel source so the output register sees control and data together.
  vga_delay_line #(
    .DEPTH   (PX_LAT),
    .WIDTH   (DW),
    .RST_VAL (DL_RST)
  ) u_dly (
    .px_clk (px_clk),
    .rst    (rst),
    .din    (raw_vec),
    .dout   (dly_vec)
  );

  logic [3*COLOR_W-1:0] rgb_next;

  always_comb begin
    rgb_next = px_data;
`ifdef VGA_TEST_PATTERN_EN
    bar = 3'((int'(d_h) * 8) / H_ACTIVE);
    if (test_sel) rgb_next = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
`endif
  end

  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      RED         <= '0;
      GRN         <= '0;
      BLU         <= '0;
      HSYNC       <= ~HS_POL;
      VSYNC       <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      HSYNC       <= dly_vec[DW-1];
      VSYNC       <= dly_vec[DW-2];
      de          <= dly_vec[DW-3];
      frame_start <= dly_vec[DW-4];
      line_start  <= dly_vec[DW-5];
      {RED, GRN, BLU} <= dly_vec[DW-3] ? rgb_next : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small mode, against a linear-pixel-index reference model.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 12, VFP = 2, VSW = 2, VBP = 4;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int PIX = HT * VT;
  localparam int L = 3, CW = 11, C = 4;
  localparam bit HSP = 1'b0, VSP = 1'b1;

  logic          px_clk = 1'b0;
  logic          rst, en;
  logic          test_sel;
  logic [3*C-1:0] px_data;
  logic [CW-1:0] px_h, px_v;
  logic          px_req, HSYNC, VSYNC, de, frame_start, line_start, running;
  logic [C-1:0]  RED, GRN, BLU;

  int checks = 0;
  int errors = 0;

  always #5 px_clk = ~px_clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .PX_LAT(L), .CW(CW), .COLOR_W(C)
  ) dut (
    .px_clk(px_clk), .rst(rst), .en(en),
`ifdef VGA_TEST_PATTERN_EN
    .test_sel(test_sel),
`endif
    .px_data(px_data), .px_h(px_h), .px_v(px_v), .px_req(px_req),
    .RED(RED), .GRN(GRN), .BLU(BLU), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .de(de), .frame_start(frame_start), .line_start(line_start), .running(running)
  );

  // Pixel source: returns the coordinate fetched L cycles ago.
  logic [CW-1:0] hist_h [L];
  logic [CW-1:0] hist_v [L];
  always @(posedge px_clk) begin
    hist_h[0] <= px_h;
    hist_v[0] <= px_v;
    for (int k = 1; k < L; k++) begin
      hist_h[k] <= hist_h[k-1];
      hist_v[k] <= hist_v[k-1];
    end
  end
  assign px_data = {hist_h[L-1][3:0], hist_v[L-1][3:0], 4'hA};

  // Reference: a running flag, a stop request, and a linear pixel index in the frame.
  typedef struct { bit de; bit fs; bit ls; bit hs; bit vs; int h; int v; } raw_t;
  raw_t q[$];
  raw_t last_e;
  bit   m_on, m_stop;
  int   m_pos;

  function automatic raw_t raw_of(bit on, int pos);
    raw_t r;
    r.h  = pos % HT;
    r.v  = pos / HT;
    r.de = on && r.h < HA && r.v < VA;
    r.fs = on && pos == 0;
    r.ls = on && r.h == 0 && r.v < VA;
    r.hs = (on && r.h >= HA + HFP && r.h < HA + HFP + HSW) ? HSP : !HSP;
    r.vs = (on && r.v >= VA + VFP && r.v < VA + VFP + VSW) ? VSP : !VSP;
    return r;
  endfunction

  function automatic logic [3*C-1:0] exp_rgb(raw_t e, logic sel);
    logic [31:0] hb, vb;
    int bar;
    hb = e.h;
    vb = e.v;
    if (!e.de) return '0;
    if (sel) begin
      bar = (e.h * 8) / HA;
      return {{C{bar[2]}}, {C{bar[1]}}, {C{bar[0]}}};
    end
    return {hb[3:0], vb[3:0], 4'hA};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_stop = 0; m_pos = 0;
    q.delete();
    for (int k = 0; k <= L; k++) q.push_back(raw_of(1'b0, 0));
  endtask

  task automatic model_advance(logic e_in);
    if (!m_on) begin
      if (e_in) begin m_on = 1; m_stop = 0; m_pos = 0; end
    end else if (e_in) begin
      m_stop = 0;
      m_pos  = (m_pos + 1) % PIX;
    end else if (m_stop && m_pos == PIX - 1) begin
      m_on = 0; m_stop = 0; m_pos = 0;
    end else begin
      m_stop = 1;
      m_pos  = (m_pos + 1) % PIX;
    end
  endtask

  task automatic step();
    raw_t cur;
    @(posedge px_clk);
    model_advance(en);
    cur = raw_of(m_on, m_pos);
    q.push_back(cur);
    last_e = q.pop_front();
    #1;
    chk("running", running, m_on);
    chk("px_req", px_req, cur.de);
    chk("px_h", px_h, cur.de ? cur.h : 0);
    chk("px_v", px_v, cur.de ? cur.v : 0);
    chk("HSYNC", HSYNC, last_e.hs);
    chk("VSYNC", VSYNC, last_e.vs);
    chk("de", de, last_e.de);
    chk("frame_start", frame_start, last_e.fs);
    chk("line_start", line_start, last_e.ls);
    chk("rgb", {RED, GRN, BLU}, exp_rgb(last_e, test_sel));
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_hsync"}, HSYNC, !HSP);
    chk({tag, "_vsync"}, VSYNC, !VSP);
    chk({tag, "_rgb"}, {RED, GRN, BLU}, 0);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_ls"}, line_start, 0);
    chk({tag, "_running"}, running, 0);
  endtask

  initial begin
    int n_de, n_ls, n_fs, n_hs, n_vs, hs_first, n;
    bit found;

    rst = 1'b1; en = 1'b0; test_sel = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge px_clk);
    #2 rst = 1'b0;
    model_reset();

    // Continuous run: measure one full frame from its frame_start.
    en = 1'b1;
    found = 0;
    for (int i = 0; i < 3 * PIX && !found; i++) begin
      step();
      if (frame_start) found = 1;
    end
    chk("fs_found", found, 1);
    n_de = 0; n_ls = 0; n_fs = 0; n_hs = 0; n_vs = 0; hs_first = -1;
    for (int i = 0; i < PIX; i++) begin
      n_de += int'(de);
      n_ls += int'(line_start);
      n_fs += int'(frame_start);
      if (HSYNC == HSP) begin
        n_hs++;
        if (hs_first < 0) hs_first = i;
      end
      if (VSYNC == VSP) n_vs++;
      step();
    end
    chk("fs_period", frame_start, 1);
    chk("fs_per_frame", n_fs, 1);
    chk("de_per_frame", n_de, HA * VA);
    chk("ls_per_frame", n_ls, VA);
    chk("hs_cycles", n_hs, HSW * VT);
    chk("hs_offset", hs_first, HA + HFP);
    chk("vs_cycles", n_vs, VSW * HT);

    // One-cycle en glitch.
    repeat (37) step();
    en = 1'b0; step();
    en = 1'b1;
    repeat (PIX + 20) step();

    // Stop request mid-frame at line 5.
    for (int i = 0; i < PIX && (m_pos / HT) != 5; i++) step();
    en = 1'b0;
    for (int i = 0; i < 2 * PIX && running; i++) step();
    chk("stop_idle", running, 0);
    repeat (L + 10) step();
    chk("idle_de", de, 0);
    en = 1'b1;
    n = 0;
    for (int i = 0; i < 50 && !(n > 0 && frame_start); i++) begin
      step();
      n++;
    end
    chk("restart_fs_lat", n, L + 2);

    // Asynchronous reset in the middle of a line.
    for (int i = 0; i < PIX && !(last_e.de && last_e.h == 7); i++) step();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midline");
    repeat (2) @(posedge px_clk);
    #2 rst = 1'b0;
    model_reset();
    repeat (L + 4) step();

    // Random en activity.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      step();
    end

`ifdef VGA_TEST_PATTERN_EN
    en = 1'b1;
    test_sel = 1'b1;
    for (int i = 0; i < 2 * PIX; i++) begin
      step();
      if (last_e.de && last_e.h == 0)  chk("bar_x0",  {RED, GRN, BLU}, 12'h000);
      if (last_e.de && last_e.h == 2)  chk("bar_x2",  {RED, GRN, BLU}, 12'h00F);
      if (last_e.de && last_e.h == HA - 1) chk("bar_xmax", {RED, GRN, BLU}, 12'hFFF);
    end
    test_sel = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
